// File: rtl/audio_pkg.sv
// Shared audio definitions: default sample width, signed sample type and
// the I2S slot indices where each channel's MSB appears.
package audio_pkg;

  localparam int DEFAULT_SAMPLE_BITS = 16;

  typedef logic signed [DEFAULT_SAMPLE_BITS-1:0] sample_t;

  // I2S delays each word by one slot relative to the lrck transition.
  localparam int LEFT_FIRST_SLOT  = 1;
  localparam int RIGHT_FIRST_SLOT = DEFAULT_SAMPLE_BITS + 1;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S timing: clk divider and slot counter producing bclk, lrck, the
// per-frame request strobe and a last-cycle-of-slot marker.
module i2s_clk_gen #(
  parameter int BCLK_HALF   = 4,
  parameter int SAMPLE_BITS = 16,
  localparam int DW = $clog2(2 * BCLK_HALF),
  localparam int SW = $clog2(2 * SAMPLE_BITS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tx_enable,
  output logic          bclk,
  output logic          lrck,
  output logic          strobe,
  output logic          slot_end,
  output logic [SW-1:0] slot_idx
);

  localparam logic [DW-1:0] DIV_LAST  = DW'(2 * BCLK_HALF - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(2 * SAMPLE_BITS - 1);

  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] slot_q, slot_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      slot_q <= '0;
    end else begin
      div_q  <= div_d;
      slot_q <= slot_d;
    end
  end

  // Disabled holds both counters at zero so enable always starts a fresh frame.
  always_comb begin
    div_d  = '0;
    slot_d = '0;
    if (tx_enable) begin
      slot_d = slot_q;
      if (div_q == DIV_LAST) begin
        slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  assign bclk     = (div_q >= DW'(BCLK_HALF));
  assign lrck     = (slot_q >= SW'(SAMPLE_BITS));
  assign slot_end = tx_enable && (div_q == DIV_LAST);
  assign slot_idx = slot_q;
  // Gated by reset so the strobe is silent while reset is held with enable high.
  assign strobe   = tx_enable && !reset && (div_q == '0) && (slot_q == '0);

endmodule

// File: rtl/i2s_sample_tx.sv
// I2S sample transmitter: requests one sample per frame and serializes it MSB
// first. Define I2S_SAMPLE_TX_STEREO_EN for a separate right-channel input.
module i2s_sample_tx
  import audio_pkg::*;
#(
  parameter int BCLK_HALF   = 4,
  parameter int SAMPLE_BITS = DEFAULT_SAMPLE_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_enable,
  input  logic signed [SAMPLE_BITS-1:0] sample_left,
`ifdef I2S_SAMPLE_TX_STEREO_EN
  input  logic signed [SAMPLE_BITS-1:0] sample_right,
`endif
  output logic                          new_sample_ready,
  output logic                          bclk,
  output logic                          lrck,
  output logic                          sdata
);

  localparam int SW = $clog2(2 * SAMPLE_BITS);

  logic          slot_end;
  logic [SW-1:0] slot_idx;
  logic          capture;
  logic [SAMPLE_BITS-1:0]   right_src;
  logic [2*SAMPLE_BITS-1:0] shift_q;

  i2s_clk_gen #(
    .BCLK_HALF  (BCLK_HALF),
    .SAMPLE_BITS(SAMPLE_BITS)
  ) u_clk_gen (
    .clk      (clk),
    .reset    (reset),
    .tx_enable(tx_enable),
    .bclk     (bclk),
    .lrck     (lrck),
    .strobe   (new_sample_ready),
    .slot_end (slot_end),
    .slot_idx (slot_idx)
  );

`ifdef I2S_SAMPLE_TX_STEREO_EN
  assign right_src = sample_right;
`else
  assign right_src = sample_left;
`endif

  assign capture = slot_end && (slot_idx == SW'(LEFT_FIRST_SLOT - 1));

  // One shift per slot boundary; the last shift of a frame leaves the right
  // LSB on sdata for slot 0 of the following frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
    end else if (!tx_enable) begin
      shift_q <= '0;
    end else if (capture) begin
      shift_q <= {sample_left, right_src};
    end else if (slot_end) begin
      shift_q <= shift_q << 1;
    end
  end

  assign sdata = shift_q[2*SAMPLE_BITS-1];

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Scoreboard bench for i2s_sample_tx: driver pushes expected {lrck,sdata}
// per slot, a monitor pops and compares at every bclk rising edge.
module tb_i2s_sample_tx;

  localparam int H     = 2;
  localparam int SB    = 16;
  localparam int SLOT  = 2 * H;
  localparam int FRAME = 2 * SB * SLOT;
`ifdef I2S_SAMPLE_TX_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_enable = 1'b0;
  logic [SB-1:0] sample_left = '0;
  logic [SB-1:0] sample_right = '0;
  logic new_sample_ready, bclk, lrck, sdata;

  logic [1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int epoch = 0;
  int t_last = 0;
  int cyc = 0;
  logic prev_r0 = 1'b0;

  i2s_sample_tx #(
    .BCLK_HALF  (H),
    .SAMPLE_BITS(SB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .tx_enable       (tx_enable),
    .sample_left     (sample_left),
`ifdef I2S_SAMPLE_TX_STEREO_EN
    .sample_right    (sample_right),
`endif
    .new_sample_ready(new_sample_ready),
    .bclk            (bclk),
    .lrck            (lrck),
    .sdata           (sdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected slot stream: slot 0 carries the previous right LSB, then the
  // left word MSB first, then right bits 15..1.
  task automatic push_slots(input logic [SB-1:0] l, input logic [SB-1:0] r, input int n);
    logic [SB-1:0] re;
    logic d;
    re = STEREO ? r : l;
    for (int s = 0; s < n; s++) begin
      if (s == 0)       d = prev_r0;
      else if (s <= SB) d = l[SB-s];
      else              d = re[2*SB-s];
      exp_q.push_back({(s >= SB), d});
    end
    prev_r0 = re[0];
  endtask

  // ---------------- driver tasks ----------------
  task automatic note_strobe(input string name);
    check(name, new_sample_ready, 1'b1);
    t_last = cyc;
  endtask

  // Entered at the negedge of a strobe cycle; leaves at the next strobe negedge.
  task automatic run_frame(input logic [SB-1:0] l, input logic [SB-1:0] r,
                           input bit late, input logic [SB-1:0] late_v);
    int n;
    push_slots(l, r, 2 * SB);
    @(posedge clk); #1;
    sample_left  = l;
    sample_right = r;
    if (late) begin
      repeat (5 * SLOT - 1) @(posedge clk);
      #1 sample_left = late_v;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!new_sample_ready && n < 2 * FRAME);
    check("strobe_spacing", cyc - t_last, FRAME);
    t_last = cyc;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic prev_b;
    logic [1:0] e;
    int last_rise;
    int last_epoch;
    prev_b = 1'b0;
    last_rise = 0;
    last_epoch = -1;
    forever begin
      @(negedge clk);
      if (bclk && !prev_b) begin
        if (last_epoch == epoch) check("bclk_period", cyc - last_rise, SLOT);
        last_rise = cyc;
        last_epoch = epoch;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL slot_unexpected: got %0b expected no slot (cycle %0d)", {lrck, sdata}, cyc);
        end else begin
          e = exp_q.pop_front();
          check("slot_lrck_sdata", {lrck, sdata}, e);
        end
      end
      prev_b = bclk;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_bclk", bclk, 1'b0);
    check("rst_lrck", lrck, 1'b0);
    check("rst_sdata", sdata, 1'b0);
    check("rst_strobe", new_sample_ready, 1'b0);

    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_strobe", new_sample_ready, 1'b0);
    check("idle_bclk", bclk, 1'b0);

    @(posedge clk); #1 tx_enable = 1'b1;
    @(negedge clk);
    note_strobe("strobe_first");

    run_frame(16'h8001, 16'h8001, 1'b0, '0);
    run_frame(16'h1234, 16'h4321, 1'b1, 16'h0F0F);
    run_frame(16'h0F0F, 16'h4321, 1'b0, '0);
    run_frame(16'h00FF, 16'hFF00, 1'b0, '0);

    // Idle: drop enable at the start of slot 10.
    push_slots(16'h5A5B, 16'h5A5B, 10);
    @(posedge clk); #1 sample_left = 16'h5A5B; sample_right = 16'h5A5B;
    repeat (10 * SLOT - 1) @(posedge clk);
    #1 tx_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("off_bclk", bclk, 1'b0);
    check("off_lrck", lrck, 1'b0);
    check("off_sdata", sdata, 1'b0);
    check("off_strobe", new_sample_ready, 1'b0);
    check("off_q_drained", exp_q.size(), 0);
    exp_q.delete();
    epoch++;
    prev_r0 = 1'b0;
    repeat (7) @(negedge clk);
    check("off_hold_bclk", bclk, 1'b0);
    check("off_hold_strobe", new_sample_ready, 1'b0);

    @(posedge clk); #1 tx_enable = 1'b1;
    @(negedge clk);
    note_strobe("strobe_reenable");
    run_frame(16'hC3A5, 16'h3C5A, 1'b0, '0);

    // Async reset in slot 20 while bclk, lrck and sdata are all high.
    push_slots(16'hFFFF, 16'hFFFF, 21);
    @(posedge clk); #1 sample_left = 16'hFFFF; sample_right = 16'hFFFF;
    repeat (20 * SLOT + H) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_bclk", bclk, 1'b0);
    check("arst_lrck", lrck, 1'b0);
    check("arst_sdata", sdata, 1'b0);
    check("arst_strobe", new_sample_ready, 1'b0);
    check("arst_q_drained", exp_q.size(), 0);
    exp_q.delete();
    epoch++;
    prev_r0 = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_hold_strobe", new_sample_ready, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    note_strobe("strobe_after_reset");
    run_frame(16'h6C39, 16'h93C6, 1'b0, '0);

    // Slot 0 of the following frame carries the last right LSB.
    exp_q.push_back({1'b0, prev_r0});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (exp_q.size() != 0 && n < 4 * SLOT);
    #1 tx_enable = 1'b0;
    check("tail_q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_sample_tx.md
Name:
i2s_sample_tx

Overview:
- Consumer end of the synth sample interface: paces voice generators by issuing `new_sample_ready` once per audio frame.
- Captures the resulting signed 16-bit sample and serializes it to the DAC as standard I2S (bclk, lrck, sdata).
- Sits between the final mix stage and the codec pins; it is the sole source of `new_sample_ready` for all sample producers.

Parameters:
- BCLK_HALF, 4, clk cycles per bclk half-period (≥2); slot length = 2*BCLK_HALF clk cycles.
- SAMPLE_BITS, 16, bits per channel; a frame = 2*SAMPLE_BITS slots.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tx_enable  in  1  run serializer; low = idle
- sample_left  in  SAMPLE_BITS  signed sample; also used for right when STEREO_EN is undefined
- sample_right  in  SAMPLE_BITS  signed right sample (present only with STEREO_EN)
- new_sample_ready  out  1  one-clk request strobe to producers
- bclk  out  1  I2S bit clock
- lrck  out  1  I2S word select (0 = left, 1 = right)
- sdata  out  1  I2S serial data, MSB first

Behaviour:
- Reset (async, immediate): all state and outputs 0; div_cnt=0, slot_cnt=0, shift register=0, held right-LSB bit=0.
- Counters:
  - div_cnt runs 0..2*BCLK_HALF-1 and wraps.
  - slot_cnt runs 0..2*SAMPLE_BITS-1; it increments when div_cnt wraps and wraps to 0.
- bclk = 0 while div_cnt < BCLK_HALF, else 1. Slot boundaries therefore fall on bclk falling edges.
- lrck = 0 for slots 0..SAMPLE_BITS-1 and 1 for slots SAMPLE_BITS..2*SAMPLE_BITS-1. It changes at the slot boundary.
- sdata carries the I2S one-slot delay and changes only at slot boundaries:
  - slot 1..SAMPLE_BITS: left bit SAMPLE_BITS-1 down to bit 0.
  - slot SAMPLE_BITS+1..2*SAMPLE_BITS-1: right bit SAMPLE_BITS-1 down to bit 1.
  - slot 0 of the next frame: right bit 0 of the previous frame.
  - First frame after enable/reset: slot 0 outputs 0.
- Strobe: new_sample_ready = 1 for exactly one clk, in the cycle slot 0 begins (slot_cnt=0, div_cnt=0), while enabled.
- Capture: sample_left/sample_right are sampled on the clk edge where slot 1 begins.
  - This is 2*BCLK_HALF cycles after the strobe, so producers that update on the strobe edge are settled.
  - Inputs are don't-care at all other times.
  - The MSB drives sdata in the same cycle it is captured.
- Idle: tx_enable low forces counters to 0 and bclk/lrck/sdata/new_sample_ready to 0, and clears the shift register.
- Start: tx_enable rising begins at slot 0, div_cnt 0, with the strobe in the first enabled cycle.
- Deassert mid-frame: outputs go to 0 next cycle. The partial frame is discarded; there is no flush.
- Signed data is passed bit-exact; the block performs no arithmetic on samples.

Optional Feature:
- Macro: I2S_SAMPLE_TX_STEREO_EN.
- Defined: sample_right port exists; right slots carry sample_right.
- Undefined: port absent; the value captured from sample_left is sent in both channels (mono duplication).

Decomposition:
- Shared package `audio_pkg`: SAMPLE_BITS default, a signed sample typedef, and the slot-index constants LEFT_FIRST_SLOT=1 and RIGHT_FIRST_SLOT=SAMPLE_BITS+1.
- One natural sub-module: `i2s_clk_gen` (div_cnt/slot_cnt, bclk, lrck, slot_start and strobe pulses).
- The top holds the capture and shift register.

Test Plan:
- Reset: assert reset mid-frame -> all outputs 0 in the same cycle with no clk edge; after release with tx_enable=1, new_sample_ready pulses in the first cycle.
- Strobe spacing: BCLK_HALF=2, SAMPLE_BITS=16 -> new_sample_ready high one clk every 128 clk; bclk period 4 clk; lrck period 128 clk, 50% duty.
- Left data: sample_left=16'sh8001 (mono) -> slots 1..16 sdata = 1,0×14,1; slots 17..31 = 1,0×14; next slot 0 = 1.
- Stereo: with the macro, L=16'sh00FF, R=16'shFF00 -> slots 1..16 = 0×8,1×8; slots 17..31 = 1×8,0×7; next slot 0 = 0.
- Handshake: producer updates the sample at the strobe edge (changes 1 clk after the strobe) -> the new value is transmitted in the same frame; a change at slot 5 is not seen until the next frame.
- Idle: drop tx_enable at slot 10 -> bclk/lrck/sdata/strobe 0 from the next cycle. Re-assert -> strobe in the first enabled cycle and slot 0 sdata=0.
